// File: rtl/dct_frame_sched.sv
// Frame sequencer for dct_top: raster-to-block pixel feed and
// coefficient tagging across the fixed DCT pipeline latency.
module dct_frame_sched #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int AW    = 16,
  parameter int LAT   = 147,
  parameter int BW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic          dct_clr,
  output logic          dct_enb,
  output logic [7:0]    dct_data_in,
  output logic          out_valid,
  output logic [BW-1:0] out_blk,
  output logic [5:0]    out_idx,
  output logic          busy,
  output logic          done
);

  localparam int NBX = IMG_W / 8;
  localparam int NBY = IMG_H / 8;
  localparam int N   = IMG_W * IMG_H;
  localparam int XW  = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int YW  = (NBY > 1) ? $clog2(NBY) : 1;
  localparam int OCW = $clog2(LAT + N + 1);

  localparam logic [XW-1:0]  X_MAX   = XW'(NBX - 1);
  localparam logic [YW-1:0]  Y_MAX   = YW'(NBY - 1);
  localparam logic [OCW-1:0] V_FIRST = OCW'(LAT);
  localparam logic [OCW-1:0] V_LAST  = OCW'(LAT + N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]     r_c;
  logic [2:0]     r_r;
  logic [XW-1:0]  r_bx;
  logic [YW-1:0]  r_by;
  logic           r_rd_d1;
  logic           r_enb;
  logic [7:0]     r_din;
  logic [OCW-1:0] r_ocnt;
  logic [BW-1:0]  r_blk;
  logic [5:0]     r_idx;

  logic          w_feed_last;
  logic          w_valid;
  logic          w_last_out;
  logic [AW-1:0] w_row;
  logic [AW-1:0] w_col;

  // by*8+r and bx*8+c are plain bit concatenations
  assign w_row = AW'({r_by, r_r});
  assign w_col = AW'({r_bx, r_c});

  assign w_feed_last = (r_state == S_FEED) && (r_c == 3'd7)
                    && (r_r == 3'd7) && (r_bx == X_MAX)
                    && (r_by == Y_MAX);
  assign w_valid     = r_enb && (r_ocnt >= V_FIRST)
                    && (r_ocnt <= V_LAST);
  assign w_last_out  = w_valid && (r_ocnt == V_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_CLR;
      S_CLR:   w_next = S_FEED;
      S_FEED:  if (w_feed_last) w_next = S_DRAIN;
      S_DRAIN: if (w_last_out) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd      = (r_state == S_FEED);
    mem_addr    = w_row * AW'(IMG_W) + w_col;
    dct_clr     = (r_state == S_CLR);
    dct_enb     = r_enb;
    dct_data_in = r_din;
    out_valid   = w_valid;
    out_blk     = r_blk;
    out_idx     = r_idx;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c     <= '0;
      r_r     <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_rd_d1 <= 1'b0;
      r_enb   <= 1'b0;
      r_din   <= '0;
      r_ocnt  <= '0;
      r_blk   <= '0;
      r_idx   <= '0;
    end else if (r_state == S_FIN) begin
      r_c     <= '0;
      r_r     <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_rd_d1 <= 1'b0;
      r_enb   <= 1'b0;
      r_din   <= '0;
      r_ocnt  <= '0;
      r_blk   <= '0;
      r_idx   <= '0;
    end else begin
      if (r_state == S_FEED) begin
        r_c <= r_c + 3'd1;
        if (r_c == 3'd7) begin
          r_r <= r_r + 3'd1;
          if (r_r == 3'd7) begin
            r_bx <= (r_bx == X_MAX) ? '0 : r_bx + 1'b1;
            if (r_bx == X_MAX)
              r_by <= (r_by == Y_MAX) ? '0 : r_by + 1'b1;
          end
        end
      end
      // RAM data lands one cycle after the read, then is registered
      r_rd_d1 <= (r_state == S_FEED);
      r_din   <= r_rd_d1 ? mem_data : 8'd0;
      if (w_next == S_FIN)
        r_enb <= 1'b0;
      else if (r_rd_d1)
        r_enb <= 1'b1;
      if (r_enb)
        r_ocnt <= r_ocnt + 1'b1;
      if (w_valid) begin
        r_idx <= r_idx + 6'd1;
        if (r_idx == 6'd63)
          r_blk <= r_blk + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dct_frame_sched.sv
// Directed bench for dct_frame_sched on a 16x16 image with a
// RAM model holding addr[7:0] at every address.
module tb_dct_frame_sched;

  localparam int W   = 16;
  localparam int H   = 16;
  localparam int AW  = 16;
  localparam int LAT = 147;
  localparam int BW  = 10;
  localparam int N   = W * H;
  localparam int KF  = 4 + LAT + N;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'd0;
  logic          dct_clr;
  logic          dct_enb;
  logic [7:0]    dct_data_in;
  logic          out_valid;
  logic [BW-1:0] out_blk;
  logic [5:0]    out_idx;
  logic          busy;
  logic          done;

  int n_cmp  = 0;
  int n_fail = 0;

  dct_frame_sched #(
    .IMG_W(W), .IMG_H(H), .AW(AW), .LAT(LAT), .BW(BW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .dct_clr(dct_clr), .dct_enb(dct_enb),
    .dct_data_in(dct_data_in), .out_valid(out_valid),
    .out_blk(out_blk), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd) mem_data <= mem_addr[7:0];

  function automatic int exp_addr(input int p);
    int blk;
    int idx;
    blk = p / 64;
    idx = p % 64;
    return ((blk / 2) * 8 + idx / 8) * W + (blk % 2) * 8 + idx % 8;
  endfunction

  // Caller leaves start=1 at a negedge in IDLE; k counts cycles after acceptance
  task automatic run_frame(input string tag, input bit inj,
                           input bit chain);
    int n_val;
    int n_done;
    int spot;
    bit e_rd, e_enb, e_val, e_done, e_busy;
    logic [7:0] e_din;
    n_val  = 0;
    n_done = 0;
    for (int k = 1; k <= KF + 1; k++) begin
      @(negedge clk);
      start  = 1'b0;
      e_rd   = (k >= 2) && (k <= N + 1);
      e_enb  = (k >= 4) && (k <= KF - 1);
      e_val  = (k >= 4 + LAT) && (k <= KF - 1);
      e_done = (k == KF);
      e_busy = (k <= KF);
      e_din  = ((k >= 4) && (k < 4 + N)) ? 8'(exp_addr(k - 4)) : 8'd0;
      n_cmp++;
      if (dct_clr !== (k == 1)) begin
        n_fail++;
        $display("FAIL %s clr k=%0d got %b exp %b", tag, k, dct_clr, k == 1);
      end
      n_cmp++;
      if (mem_rd !== e_rd) begin
        n_fail++;
        $display("FAIL %s mem_rd k=%0d got %b exp %b", tag, k, mem_rd, e_rd);
      end
      if (e_rd) begin
        n_cmp++;
        if (mem_addr !== AW'(exp_addr(k - 2))) begin
          n_fail++;
          $display("FAIL %s addr k=%0d got %0d exp %0d", tag, k,
                   mem_addr, exp_addr(k - 2));
        end
        spot = -1;
        case (k - 2)
          0:   spot = 0;
          8:   spot = 16;
          63:  spot = 119;
          64:  spot = 8;
          72:  spot = 24;
          255: spot = 255;
          default: spot = -1;
        endcase
        if (spot >= 0) begin
          n_cmp++;
          if (mem_addr !== AW'(spot)) begin
            n_fail++;
            $display("FAIL %s addr_spot pix=%0d got %0d exp %0d", tag,
                     k - 2, mem_addr, spot);
          end
        end
      end
      n_cmp++;
      if (dct_enb !== e_enb) begin
        n_fail++;
        $display("FAIL %s enb k=%0d got %b exp %b", tag, k, dct_enb, e_enb);
      end
      n_cmp++;
      if (dct_data_in !== e_din) begin
        n_fail++;
        $display("FAIL %s din k=%0d got %0d exp %0d", tag, k,
                 dct_data_in, e_din);
      end
      n_cmp++;
      if (out_valid !== e_val) begin
        n_fail++;
        $display("FAIL %s valid k=%0d got %b exp %b", tag, k,
                 out_valid, e_val);
      end
      if (e_val) begin
        n_cmp++;
        if (out_blk !== BW'((k - 4 - LAT) / 64)
            || out_idx !== 6'((k - 4 - LAT) % 64)) begin
          n_fail++;
          $display("FAIL %s tag k=%0d got blk %0d idx %0d exp %0d %0d",
                   tag, k, out_blk, out_idx, (k - 4 - LAT) / 64,
                   (k - 4 - LAT) % 64);
        end
      end
      n_cmp++;
      if (done !== e_done) begin
        n_fail++;
        $display("FAIL %s done k=%0d got %b exp %b", tag, k, done, e_done);
      end
      n_cmp++;
      if (busy !== e_busy) begin
        n_fail++;
        $display("FAIL %s busy k=%0d got %b exp %b", tag, k, busy, e_busy);
      end
      if (out_valid === 1'b1) n_val++;
      if (done === 1'b1) n_done++;
      if (inj && (k == 50 || k == KF)) start = 1'b1;
      if (chain && k == KF + 1) start = 1'b1;
    end
    n_cmp++;
    if (n_val != N || n_done != 1) begin
      n_fail++;
      $display("FAIL %s counts got valid %0d done %0d exp %0d 1", tag,
               n_val, n_done, N);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_rd, mem_addr, dct_clr, dct_enb, dct_data_in, out_valid,
           out_blk, out_idx, busy, done} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold outputs not zero busy=%b addr=%0d",
                 busy, mem_addr);
      end
    end
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_rd, mem_addr, dct_clr, dct_enb, dct_data_in, out_valid,
           out_blk, out_idx, busy, done} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle outputs not zero busy=%b addr=%0d",
                 busy, mem_addr);
      end
    end
  endtask

  task automatic test_frame();
    @(negedge clk);
    start = 1'b1;
    run_frame("frame", 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    start = 1'b1;
    run_frame("ignore", 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || dct_clr !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_fin_start got busy %b clr %b exp 0 0",
                 busy, dct_clr);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 102; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if (mem_addr !== AW'(76)) begin
      n_fail++;
      $display("FAIL midrst_addr got %0d exp 76", mem_addr);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_rd, mem_addr, dct_clr, dct_enb, dct_data_in, out_valid,
         out_blk, out_idx, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs not zero busy=%b rd=%b addr=%0d",
               busy, mem_rd, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    run_frame("after_rst", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1;
    run_frame("b2b_a", 1'b0, 1'b1);
    run_frame("b2b_b", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_cmp, n_fail);
    $finish;
  end

endmodule
